// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_engine
// Purpose  : SD-card SPI-mode command engine. Frames a 48-bit command
//            (start/transmission bits, index, argument, CRC7, end bit), sends
//            it a byte at a time to the SPI byte shifter over a four-phase
//            SendReq/SendAck handshake, then clocks 0xFF fill bytes to poll
//            for and capture an R1/R3/R7 response with a bounded NCR timeout.
// Ports    : Clk, nReset              - clock, async active-low reset
//            SendData/SendReq/SendAck - byte handshake towards the shifter
//            RecvData                 - byte received in the same transfer
//            Command/Args/CRC/RespBytes - command request fields
//            CmdSend/CmdAck           - four-phase command handshake
//            Busy, Timeout, Resp      - status and captured response
// Config   : define SD_CMD_CRC_GEN_EN to generate CRC7 internally; otherwise
//            the CRC input port supplies the frame checksum.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_engine #(
    parameter int PRE_FF   = 1,
    parameter int MAX_RESP = 5,
    parameter int NCR_MAX  = 8
) (
    input  logic                  Clk,
    input  logic                  nReset,
    output logic [7:0]            SendData,
    output logic                  SendReq,
    input  logic                  SendAck,
    input  logic [7:0]            RecvData,
    input  logic [5:0]            Command,
    input  logic [31:0]           Args,
    input  logic [6:0]            CRC,
    input  logic [3:0]            RespBytes,
    input  logic                  CmdSend,
    output logic                  CmdAck,
    output logic                  Busy,
    output logic                  Timeout,
    output logic [8*MAX_RESP-1:0] Resp
);

    typedef enum logic [3:0] {
        IDLE, LOAD, PRE, XFER_REQ, XFER_WAIT, NEXT, POLL, RESP, DONE
    } state_t;

    localparam logic [3:0] PRE_CNT  = 4'(PRE_FF);
    localparam logic [3:0] RESP_MAX = 4'(MAX_RESP);
    localparam logic [7:0] NCR_LIM  = 8'(NCR_MAX);

    state_t      state;
    state_t      phase;     // which sending phase NEXT returns to: PRE, POLL or RESP
    logic [5:0]  cmd_q;
    logic [31:0] arg_q;
    logic [3:0]  pre_cnt;
    logic [2:0]  byte_idx;  // frame bytes already handed to XFER
    logic [7:0]  poll_cnt;
    logic [3:0]  resp_idx;
    logic [3:0]  resp_len;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;
    logic [6:0]  crc7;
    logic [7:0]  frame_byte;
    logic [7:0]  poll_next;

    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

`ifdef SD_CMD_CRC_GEN_EN
    logic crc_port_unused;
    assign crc_port_unused = ^CRC;
    assign crc7 = crc7_calc({2'b01, cmd_q, arg_q});
`else
    logic [6:0] crc_q;
    assign crc7 = crc_q;
`endif

    always_comb begin
        case (byte_idx)
            3'd0:    frame_byte = {2'b01, cmd_q};
            3'd1:    frame_byte = arg_q[31:24];
            3'd2:    frame_byte = arg_q[23:16];
            3'd3:    frame_byte = arg_q[15:8];
            3'd4:    frame_byte = arg_q[7:0];
            default: frame_byte = {crc7, 1'b1};
        endcase
    end

    // Saturating poll count so a large NCR_MAX can never wrap to zero.
    assign poll_next = (poll_cnt == 8'hFF) ? 8'hFF : poll_cnt + 8'd1;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            phase    <= PRE;
            cmd_q    <= '0;
            arg_q    <= '0;
`ifndef SD_CMD_CRC_GEN_EN
            crc_q    <= '0;
`endif
            pre_cnt  <= '0;
            byte_idx <= '0;
            poll_cnt <= '0;
            resp_idx <= '0;
            resp_len <= '0;
            tx_byte  <= 8'hFF;
            rx_byte  <= 8'hFF;
            SendData <= 8'hFF;
            SendReq  <= 1'b0;
            CmdAck   <= 1'b0;
            Busy     <= 1'b0;
            Timeout  <= 1'b0;
            Resp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CmdSend) state <= LOAD;
                end
                LOAD: begin
                    cmd_q    <= Command;
                    arg_q    <= Args;
`ifndef SD_CMD_CRC_GEN_EN
                    crc_q    <= CRC;
`endif
                    resp_len <= (RespBytes == 4'd0 || RespBytes > RESP_MAX) ? RESP_MAX : RespBytes;
                    Resp     <= '0;
                    Timeout  <= 1'b0;
                    Busy     <= 1'b1;
                    CmdAck   <= 1'b1;
                    pre_cnt  <= '0;
                    poll_cnt <= '0;
                    resp_idx <= '0;
                    phase    <= PRE;
                    if (PRE_FF > 0) begin
                        byte_idx <= 3'd0;
                        state    <= PRE;
                    end else begin
                        // No fill bytes: byte 0 comes straight from the inputs
                        // being latched on this same edge.
                        tx_byte  <= {2'b01, Command};
                        byte_idx <= 3'd1;
                        state    <= XFER_REQ;
                    end
                end
                PRE: begin
                    if (pre_cnt < PRE_CNT) begin
                        tx_byte <= 8'hFF;
                        pre_cnt <= pre_cnt + 4'd1;
                    end else begin
                        tx_byte  <= frame_byte;
                        byte_idx <= byte_idx + 3'd1;
                    end
                    state <= XFER_REQ;
                end
                POLL, RESP: begin
                    tx_byte <= 8'hFF;
                    state   <= XFER_REQ;
                end
                XFER_REQ: begin
                    if (!SendAck) begin
                        SendData <= tx_byte;
                        SendReq  <= 1'b1;
                        state    <= XFER_WAIT;
                    end
                end
                XFER_WAIT: begin
                    if (SendAck) begin
                        SendReq <= 1'b0;
                        rx_byte <= RecvData;
                        state   <= NEXT;
                    end
                end
                NEXT: begin
                    case (phase)
                        PRE: begin
                            if (byte_idx == 3'd6) begin
                                phase <= POLL;
                                state <= POLL;
                            end else begin
                                state <= PRE;
                            end
                        end
                        POLL: begin
                            if (!rx_byte[7]) begin
                                Resp[8*MAX_RESP-1 -: 8] <= rx_byte;
                                resp_idx <= 4'd1;
                                if (resp_len == 4'd1) begin
                                    SendData <= 8'hFF;
                                    state    <= DONE;
                                end else begin
                                    phase <= RESP;
                                    state <= RESP;
                                end
                            end else begin
                                poll_cnt <= poll_next;
                                if (poll_next >= NCR_LIM) begin
                                    Timeout  <= 1'b1;
                                    SendData <= 8'hFF;
                                    state    <= DONE;
                                end else begin
                                    state <= POLL;
                                end
                            end
                        end
                        default: begin
                            for (int i = 1; i < MAX_RESP; i++) begin
                                if (resp_idx == 4'(i)) Resp[8*(MAX_RESP-1-i) +: 8] <= rx_byte;
                            end
                            resp_idx <= resp_idx + 4'd1;
                            if (resp_idx + 4'd1 == resp_len) begin
                                SendData <= 8'hFF;
                                state    <= DONE;
                            end else begin
                                state <= RESP;
                            end
                        end
                    endcase
                end
                DONE: begin
                    if (!CmdSend && !SendAck) begin
                        CmdAck <= 1'b0;
                        Busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_engine
// Purpose  : Self-checking bench for sd_cmd_engine: behavioural SPI shifter,
//            table of directed command vectors, hand-written reset and held
//            CmdSend sequences, and random commands against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sd_cmd_engine;

    localparam int PRE_FF   = 1;
    localparam int MAX_RESP = 5;
    localparam int NCR_MAX  = 8;

    logic                  clk = 1'b0;
    logic                  nReset;
    logic [7:0]            SendData;
    logic                  SendReq;
    logic                  SendAck;
    logic [7:0]            RecvData;
    logic [5:0]            Command;
    logic [31:0]           Args;
    logic [6:0]            CRC;
    logic [3:0]            RespBytes;
    logic                  CmdSend;
    logic                  CmdAck;
    logic                  Busy;
    logic                  Timeout;
    logic [8*MAX_RESP-1:0] Resp;

    always #5 clk = ~clk;

    sd_cmd_engine #(.PRE_FF(PRE_FF), .MAX_RESP(MAX_RESP), .NCR_MAX(NCR_MAX)) dut (
        .Clk(clk), .nReset(nReset), .SendData(SendData), .SendReq(SendReq),
        .SendAck(SendAck), .RecvData(RecvData), .Command(Command), .Args(Args),
        .CRC(CRC), .RespBytes(RespBytes), .CmdSend(CmdSend), .CmdAck(CmdAck),
        .Busy(Busy), .Timeout(Timeout), .Resp(Resp)
    );

    int         total = 0;
    int         bad   = 0;
    int         stall_at = -1;
    logic [7:0] rx_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] stim_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural byte shifter: records each requested byte, answers with the
    // next queued receive byte (0xFF when empty) after 0..2 cycles.
    initial begin
        SendAck  = 1'b0;
        RecvData = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (nReset && SendReq && !SendAck && sent_q.size() != stall_at) begin
                sent_q.push_back(SendData);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (rx_q.size() > 0) RecvData = rx_q.pop_front();
                else                 RecvData = 8'hFF;
                SendAck = 1'b1;
                for (int g = 0; g < 50 && SendReq; g++) begin @(posedge clk); #1; end
                SendAck  = 1'b0;
                RecvData = 8'($urandom);
            end
        end
    end

    // CRC7 by long division of the 40 frame bits (times x^7) by x^7+x^3+1.
    function automatic logic [6:0] ref_crc(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'h89 << (i - 7));
        return r[6:0];
    endfunction

    // Reference: poll bytes after the frame, first byte with bit7 clear starts
    // the response, NCR_MAX non-start bytes means timeout.
    function automatic void model(input logic [3:0] nresp, output logic [39:0] resp,
                                  output logic to, output int polls);
        int         n;
        int         start;
        logic [7:0] b;
        n     = (nresp == 0 || nresp > MAX_RESP) ? MAX_RESP : int'(nresp);
        resp  = '0;
        to    = 1'b1;
        polls = NCR_MAX;
        start = -1;
        for (int p = 0; p < NCR_MAX; p++) begin
            b = (p < stim_q.size()) ? stim_q[p] : 8'hFF;
            if (!b[7]) begin start = p; break; end
        end
        if (start >= 0) begin
            to    = 1'b0;
            polls = start + n;
            for (int k = 0; k < n; k++)
                resp[39-8*k -: 8] = (start + k < stim_q.size()) ? stim_q[start+k] : 8'hFF;
        end
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_rx();
        rx_q.delete();
        sent_q.delete();
        for (int i = 0; i < PRE_FF + 6; i++) rx_q.push_back(8'($urandom));
        foreach (stim_q[i]) rx_q.push_back(stim_q[i]);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (Busy && k < 3000) begin step(); k++; end
        chk({tag, "_busy_end"}, 64'(Busy), 64'd0);
    endtask

    task automatic run_txn(input string tag, input logic [5:0] cmd, input logic [31:0] args,
                           input logic [6:0] crc, input logic [3:0] nresp, input logic [7:0] exp_b5,
                           input logic [39:0] exp_resp, input logic exp_to, input int exp_polls);
        int          k;
        int          nonff;
        logic [47:0] frame;
        load_rx();
        Command = cmd; Args = args; CRC = crc; RespBytes = nresp; CmdSend = 1'b1;
        k = 0;
        do begin step(); k++; end while (!CmdAck && k < 20);
        chk({tag, "_ack_latency"}, 64'(k), 64'd2);
        // Inputs after acceptance must not matter.
        Command = 6'($urandom); Args = $urandom; CRC = 7'($urandom); RespBytes = 4'($urandom);
        CmdSend = 1'b0;
        wait_idle(tag);
        chk({tag, "_nsent"}, 64'(sent_q.size()), 64'(PRE_FF + 6 + exp_polls));
        if (sent_q.size() == PRE_FF + 6 + exp_polls) begin
            frame = '0;
            nonff = 0;
            for (int i = 0; i < 6; i++) frame = {frame[39:0], sent_q[PRE_FF+i]};
            for (int i = 0; i < sent_q.size(); i++)
                if ((i < PRE_FF || i >= PRE_FF + 6) && sent_q[i] != 8'hFF) nonff++;
            chk({tag, "_frame"}, 64'(frame), 64'({2'b01, cmd, args, exp_b5}));
            chk({tag, "_fill_bytes"}, 64'(nonff), 64'd0);
        end
        chk({tag, "_resp"}, 64'(Resp), 64'(exp_resp));
        chk({tag, "_timeout"}, 64'(Timeout), 64'(exp_to));
        chk({tag, "_ack_low"}, 64'(CmdAck), 64'd0);
    endtask

    typedef struct {
        logic [5:0]  cmd;
        logic [31:0] args;
        logic [6:0]  crc;
        logic [3:0]  nresp;
        logic [63:0] stream;   // shifter bytes after the frame, first in [63:56]
        int          slen;
        logic [7:0]  b5;
        logic [39:0] resp;
        logic        to;
        int          polls;
    } vec_t;

    vec_t vt[8];

    task automatic set_stim(input logic [63:0] s, input int len);
        logic [63:0] t;
        t = s;
        stim_q.delete();
        for (int i = 0; i < len; i++) begin
            stim_q.push_back(t[63:56]);
            t = t << 8;
        end
    endtask

    initial begin
        logic [7:0]  b5;
        logic [39:0] mresp;
        logic        mto;
        int          mpolls;
        int          k;
        logic [7:0]  zero_crc_b5;
        logic [5:0]  rc;
        logic [31:0] ra;
        logic [6:0]  rcrc;
        logic [3:0]  rn;
        int          npre;

`ifdef SD_CMD_CRC_GEN_EN
        zero_crc_b5 = 8'h95;
`else
        zero_crc_b5 = 8'h01;
`endif
        vt[0] = '{6'd0,  32'h0,      7'h4A, 4'd1, 64'h01 << 56, 1, 8'h95, 40'h01_0000_0000, 1'b0, 1};
        vt[1] = '{6'd8,  32'h1AA,    7'h43, 4'd5, 64'hFF01000001AA0000, 6, 8'h87, 40'h01_0000_01AA, 1'b0, 6};
        vt[2] = '{6'd1,  32'h0,      7'h7C, 4'd1, 64'h0, 0, 8'hF9, 40'h0, 1'b1, 8};
        vt[3] = '{6'd0,  32'h0,      7'h00, 4'd1, 64'h01 << 56, 1, zero_crc_b5, 40'h01_0000_0000, 1'b0, 1};
        vt[4] = '{6'd58, 32'h0,      7'h7E, 4'd0, 64'hFFFF00FF80000000, 7, 8'hFD, 40'h00_FF80_0000, 1'b0, 7};
        vt[5] = '{6'd55, 32'h0,      7'h32, 4'd1, 64'hFFFFFFFFFFFFFF01, 8, 8'h65, 40'h01_0000_0000, 1'b0, 8};
        vt[6] = '{6'd8,  32'h1AA,    7'h43, 4'd9, 64'h01000001AA550000, 6, 8'h87, 40'h01_0000_01AA, 1'b0, 5};
        vt[7] = '{6'd0,  32'h0,      7'h4A, 4'd2, 64'hC0FE3C0000000000, 3, 8'h95, 40'h3C_FF00_0000, 1'b0, 4};

        nReset = 1'b1; CmdSend = 1'b0; Command = '0; Args = '0; CRC = '0; RespBytes = '0;
        #2 nReset = 1'b0;
        repeat (3) step();
        chk("rst_senddata", 64'(SendData), 64'hFF);
        chk("rst_sendreq",  64'(SendReq),  64'd0);
        chk("rst_cmdack",   64'(CmdAck),   64'd0);
        chk("rst_busy",     64'(Busy),     64'd0);
        chk("rst_timeout",  64'(Timeout),  64'd0);
        chk("rst_resp",     64'(Resp),     64'd0);
        nReset = 1'b1;
        repeat (2) step();

        for (int v = 0; v < 8; v++) begin
            set_stim(vt[v].stream, vt[v].slen);
            run_txn($sformatf("vec%0d", v), vt[v].cmd, vt[v].args, vt[v].crc, vt[v].nresp,
                    vt[v].b5, vt[v].resp, vt[v].to, vt[v].polls);
        end

        // CmdSend held high after completion: no second frame.
        set_stim(64'h01 << 56, 1);
        load_rx();
        Command = 6'd0; Args = '0; CRC = 7'h4A; RespBytes = 4'd1; CmdSend = 1'b1;
        k = 0;
        while (sent_q.size() < PRE_FF + 7 && k < 500) begin step(); k++; end
        repeat (20) step();
        chk("held_ack",   64'(CmdAck), 64'd1);
        chk("held_busy",  64'(Busy),   64'd1);
        chk("held_nsent", 64'(sent_q.size()), 64'(PRE_FF + 7));
        CmdSend = 1'b0;
        wait_idle("held");
        chk("held_release_ack", 64'(CmdAck), 64'd0);

        // Reset while a frame byte request is outstanding.
        stim_q.delete();
        load_rx();
        stall_at = 3;
        Command = 6'd0; Args = '0; CRC = 7'h4A; RespBytes = 4'd1; CmdSend = 1'b1;
        k = 0;
        while (!(SendReq && !SendAck && sent_q.size() == 3) && k < 300) begin step(); k++; end
        chk("mid_stall_reached", 64'(SendReq), 64'd1);
        nReset = 1'b0;
        step();
        chk("mid_rst_sendreq",  64'(SendReq),  64'd0);
        chk("mid_rst_senddata", 64'(SendData), 64'hFF);
        chk("mid_rst_cmdack",   64'(CmdAck),   64'd0);
        chk("mid_rst_busy",     64'(Busy),     64'd0);
        CmdSend = 1'b0;
        stall_at = -1;
        step();
        nReset = 1'b1;
        repeat (2) step();
        set_stim(64'h01 << 56, 1);
        run_txn("after_rst", 6'd0, 32'h0, 7'h4A, 4'd1, 8'h95, 40'h01_0000_0000, 1'b0, 1);

        // Random commands against the reference model.
        for (int t = 0; t < 25; t++) begin
            rc   = 6'($urandom);
            ra   = $urandom;
            rcrc = 7'($urandom);
            rn   = 4'($urandom);
            npre = $urandom_range(0, 9);
            stim_q.delete();
            for (int i = 0; i < npre; i++) stim_q.push_back(8'($urandom) | 8'h80);
            stim_q.push_back(8'($urandom) & 8'h7F);
            for (int i = 0; i < 7; i++) stim_q.push_back(8'($urandom));
`ifdef SD_CMD_CRC_GEN_EN
            b5 = {ref_crc({2'b01, rc, ra}), 1'b1};
`else
            b5 = {rcrc, 1'b1};
`endif
            model(rn, mresp, mto, mpolls);
            run_txn($sformatf("rnd%0d", t), rc, ra, rcrc, rn, b5, mresp, mto, mpolls);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
